// File: rtl/bus_responder_6502_pkg.sv
// Shared definitions for the 6502 bus responder: register offsets, CTRL/STAT
// bit positions and the read FSM state type.
package bus_responder_6502_pkg;

  localparam logic [1:0] REG_RLD_LO = 2'd0;
  localparam logic [1:0] REG_RLD_HI = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STAT   = 2'd3;

  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_AUTO  = 1;
  localparam int unsigned CTRL_IRQEN = 2;
  localparam int unsigned STAT_FLAG  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2
  } rd_state_e;

endpackage

// File: rtl/bus_responder_6502_timer.sv
// 16-bit down-timer behind the 4-byte register window; raises IRQ_L when the
// count expires with IRQEN set.
module bus_timer_6502
  import bus_responder_6502_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       wr_en_i,
  input  logic [1:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic       irq_l_o
);

  logic [15:0] reload_q, reload_d;
  logic [15:0] count_q, count_d;
  logic        en_q, en_d;
  logic        auto_q, auto_d;
  logic        irqen_q, irqen_d;
  logic        flag_q, flag_d;
  logic        fire;

  always_comb begin
    reload_d = reload_q;
    count_d  = count_q;
    en_d     = en_q;
    auto_d   = auto_q;
    irqen_d  = irqen_q;
    flag_d   = flag_q;
    fire     = en_q && (count_q == '0);

    if (en_q) begin
      if (fire) begin
        flag_d = 1'b1;
        if (auto_q) count_d = reload_q;
        else        en_d    = 1'b0;
      end else begin
        count_d = count_q - 16'd1;
      end
    end

    // CPU writes take priority over the count step; an expiring count beats W1C.
    if (wr_en_i) begin
      case (addr_i)
        REG_RLD_LO: reload_d[7:0] = wdata_i;
        REG_RLD_HI: begin
          reload_d[15:8] = wdata_i;
          count_d        = {wdata_i, reload_q[7:0]};
        end
        REG_CTRL: begin
          en_d    = wdata_i[CTRL_EN];
          auto_d  = wdata_i[CTRL_AUTO];
          irqen_d = wdata_i[CTRL_IRQEN];
        end
        REG_STAT: if (wdata_i[STAT_FLAG] && !fire) flag_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reload_q <= '0;
      count_q  <= '0;
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      irqen_q  <= 1'b0;
      flag_q   <= 1'b0;
    end else begin
      reload_q <= reload_d;
      count_q  <= count_d;
      en_q     <= en_d;
      auto_q   <= auto_d;
      irqen_q  <= irqen_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (addr_i)
      REG_RLD_LO: rdata_o = reload_q[7:0];
      REG_RLD_HI: rdata_o = count_q[15:8];
      REG_CTRL:   rdata_o = {5'b00000, irqen_q, auto_q, en_q};
      REG_STAT:   rdata_o = {7'b0000000, flag_q};
      default:    rdata_o = '0;
    endcase
  end

  assign irq_l_o = ~(flag_q & irqen_q);

endmodule

// File: rtl/bus_responder_6502.sv
// Target side of the 6502C external bus: RAM window with RDY-stretched reads
// and a register window hosting the interrupt timer.
module bus_responder_6502
  import bus_responder_6502_pkg::*;
#(
  parameter logic [15:0] MEM_BASE  = 16'h0000,
  parameter int unsigned MEM_AW    = 10,
  parameter int unsigned READ_WAIT = 2,
  parameter logic [15:0] REG_BASE  = 16'hD200
) (
  input  logic        phi0_in,
  input  logic        RES_L,
  input  logic [15:0] extAB,
  input  logic        RW,
  input  logic [7:0]  extDB_in,
  output logic [7:0]  extDB_out,
  output logic        extDB_oe,
  output logic        RDY,
  output logic        IRQ_L
);

  localparam int unsigned DEPTH = 1 << MEM_AW;

  logic [7:0]        mem_q [DEPTH];
  rd_state_e         state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [15:0]       addr_q, addr_d;
  logic              reg_hit, mem_hit, abort;
  logic [MEM_AW-1:0] mem_idx;
  logic [7:0]        reg_rdata;
  logic              rdy_c, oe_c;
  logic [7:0]        data_c;

  assign reg_hit = (extAB[15:2] == REG_BASE[15:2]);
  assign mem_hit = ((extAB >> MEM_AW) == (MEM_BASE >> MEM_AW)) && !reg_hit;
  assign mem_idx = extAB[MEM_AW-1:0];
  assign abort   = (extAB != addr_q) || !RW;

  bus_timer_6502 u_timer (
    .clk_i   (phi0_in),
    .rst_ni  (RES_L),
    .wr_en_i (!RW && reg_hit),
    .addr_i  (extAB[1:0]),
    .wdata_i (extDB_in),
    .rdata_o (reg_rdata),
    .irq_l_o (IRQ_L)
  );

  always_ff @(posedge phi0_in) begin
    if (RES_L && !RW && mem_hit) mem_q[mem_idx] <= extDB_in;
  end

  // The IDLE decode cycle is the first stall cycle, so WAIT counts READ_WAIT-1 more.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    rdy_c   = 1'b1;
    oe_c    = 1'b0;
    data_c  = '0;
    case (state_q)
      ST_IDLE: begin
        if (RW && reg_hit) begin
          oe_c   = 1'b1;
          data_c = reg_rdata;
        end else if (RW && mem_hit) begin
          if (READ_WAIT == 0) begin
            oe_c   = 1'b1;
            data_c = mem_q[mem_idx];
          end else begin
            rdy_c   = 1'b0;
            addr_d  = extAB;
            wcnt_d  = 4'(READ_WAIT - 2);
            state_d = (READ_WAIT == 1) ? ST_DATA : ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        rdy_c = !RW;
        if (abort)              state_d = ST_IDLE;
        else if (wcnt_q == '0)  state_d = ST_DATA;
        else                    wcnt_d  = wcnt_q - 4'd1;
      end
      ST_DATA: begin
        state_d = ST_IDLE;
        if (!abort) begin
          oe_c   = 1'b1;
          data_c = mem_q[mem_idx];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge phi0_in or negedge RES_L) begin
    if (!RES_L) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
    end
  end

  // Reset releases the bus at once, even while a decode would otherwise stall.
  always_comb begin
    RDY       = rdy_c | ~RES_L;
    extDB_oe  = oe_c & RES_L;
    extDB_out = extDB_oe ? data_c : '0;
  end

endmodule

// File: tb/tb_bus_responder_6502.sv
// Bench for bus_responder_6502: three instances (READ_WAIT 2/0/3) share one bus;
// read data is checked through an expected-data queue.
module tb_bus_responder_6502;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ab;
  logic        rw;
  logic [7:0]  din;
  logic [7:0]  dout [3];
  logic        oe   [3];
  logic        rdy  [3];
  logic        irq  [3];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned sel   = 0;
  logic [7:0]  exp_q [$];

  always #5 clk = ~clk;

  bus_responder_6502 #(.READ_WAIT(2)) u_w2 (
    .phi0_in(clk), .RES_L(rst_n), .extAB(ab), .RW(rw), .extDB_in(din),
    .extDB_out(dout[0]), .extDB_oe(oe[0]), .RDY(rdy[0]), .IRQ_L(irq[0]));
  bus_responder_6502 #(.READ_WAIT(0)) u_w0 (
    .phi0_in(clk), .RES_L(rst_n), .extAB(ab), .RW(rw), .extDB_in(din),
    .extDB_out(dout[1]), .extDB_oe(oe[1]), .RDY(rdy[1]), .IRQ_L(irq[1]));
  bus_responder_6502 #(.READ_WAIT(3)) u_w3 (
    .phi0_in(clk), .RES_L(rst_n), .extAB(ab), .RW(rw), .extDB_in(din),
    .extDB_out(dout[2]), .extDB_oe(oe[2]), .RDY(rdy[2]), .IRQ_L(irq[2]));

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive after the edge, return at mid-cycle for sampling.
  task automatic cyc(input logic [15:0] a, input logic r, input logic [7:0] d,
                     input bit push, input logic [7:0] e);
    @(posedge clk);
    #1;
    ab = a; rw = r; din = d;
    if (push) exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cyc(a, 1'b0, d, 1'b0, 8'h00);
  endtask
  task automatic rd(input logic [15:0] a, input logic [7:0] e);
    cyc(a, 1'b1, 8'h00, 1'b1, e);
  endtask
  task automatic hold(input logic [15:0] a);
    cyc(a, 1'b1, 8'h00, 1'b0, 8'h00);
  endtask
  task automatic idle();
    cyc(16'hFFFF, 1'b1, 8'h00, 1'b0, 8'h00);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && oe[sel] === 1'b1 && rdy[sel] === 1'b1) begin
      check_eq("sb_have_exp", 16'(exp_q.size() != 0), 16'd1);
      if (exp_q.size() != 0) check_eq("sb_rd_data", 16'(dout[sel]), 16'(exp_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; ab = 16'hFFFF; rw = 1'b1; din = 8'h00;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq("rst_rdy",  16'(rdy[i]),  16'd1);
      check_eq("rst_irq",  16'(irq[i]),  16'd1);
      check_eq("rst_oe",   16'(oe[i]),   16'd0);
      check_eq("rst_dout", 16'(dout[i]), 16'h0000);
    end
    rst_n = 1'b1;

    // READ_WAIT=2 RAM read
    sel = 0;
    wr(16'h0123, 8'hA5);
    check_eq("wr_rdy", 16'(rdy[0]), 16'd1);
    check_eq("wr_oe",  16'(oe[0]),  16'd0);
    wr(16'h0200, 8'h5A);
    wr(16'h03FF, 8'h3C);
    rd(16'h0123, 8'hA5);
    check_eq("w2_stall1", 16'(rdy[0]), 16'd0);
    check_eq("w2_stall1_oe", 16'(oe[0]), 16'd0);
    hold(16'h0123);
    check_eq("w2_stall2", 16'(rdy[0]), 16'd0);
    hold(16'h0123);
    check_eq("w2_data_rdy", 16'(rdy[0]), 16'd1);
    check_eq("w2_data_oe",  16'(oe[0]),  16'd1);
    idle();
    check_eq("w2_oe_once", 16'(oe[0]), 16'd0);

    // READ_WAIT=0 RAM read and window miss
    sel = 1;
    rd(16'h03FF, 8'h3C);
    check_eq("w0_rdy", 16'(rdy[1]), 16'd1);
    check_eq("w0_oe",  16'(oe[1]),  16'd1);
    rd(16'h0123, 8'hA5);
    check_eq("w0_rdy2", 16'(rdy[1]), 16'd1);
    hold(16'h0400);
    check_eq("w0_miss_oe",  16'(oe[1]),  16'd0);
    check_eq("w0_miss_rdy", 16'(rdy[1]), 16'd1);

    // register readback
    wr(16'hD200, 8'h34);
    wr(16'hD201, 8'h12);
    rd(16'hD201, 8'h12);
    rd(16'hD200, 8'h34);
    wr(16'hD202, 8'hFA);
    rd(16'hD202, 8'h02);
    wr(16'hD202, 8'h00);

    // one-shot timer, reload 3
    wr(16'hD200, 8'h03);
    wr(16'hD201, 8'h00);
    wr(16'hD202, 8'h05);
    for (int k = 0; k < 4; k++) begin
      rd(16'hD203, 8'h00);
      check_eq("os_irq_high", 16'(irq[1]), 16'd1);
    end
    rd(16'hD203, 8'h01);
    check_eq("os_irq_low", 16'(irq[1]), 16'd0);
    rd(16'hD202, 8'h04);
    rd(16'hD201, 8'h00);
    check_eq("os_irq_hold", 16'(irq[1]), 16'd0);
    wr(16'hD203, 8'h01);
    idle();
    check_eq("w1c_clear", 16'(irq[1]), 16'd1);

    // AUTO, reload 1: fires on every second edge after the CTRL write
    wr(16'hD200, 8'h01);
    wr(16'hD201, 8'h00);
    wr(16'hD202, 8'h07);
    idle();
    idle();
    wr(16'hD203, 8'h01);
    check_eq("auto_fire1", 16'(irq[1]), 16'd0);
    wr(16'hD203, 8'h01);
    check_eq("auto_w1c_clr", 16'(irq[1]), 16'd1);
    idle();
    check_eq("collide_set_wins", 16'(irq[1]), 16'd0);
    rd(16'hD203, 8'h01);
    check_eq("collide_hold", 16'(irq[1]), 16'd0);
    wr(16'hD202, 8'h00);
    wr(16'hD203, 8'h01);
    idle();
    check_eq("irq_released", 16'(irq[1]), 16'd1);

    // READ_WAIT=3 abort on the second stall cycle
    sel = 2;
    hold(16'h0123);
    check_eq("ab_stall1", 16'(rdy[2]), 16'd0);
    rd(16'h0200, 8'h5A);
    check_eq("ab_abort_cyc", 16'(rdy[2]), 16'd0);
    for (int k = 0; k < 3; k++) begin
      hold(16'h0200);
      check_eq("ab_fresh_stall", 16'(rdy[2]), 16'd0);
    end
    hold(16'h0200);
    check_eq("ab_data_rdy", 16'(rdy[2]), 16'd1);
    check_eq("ab_data_oe",  16'(oe[2]),  16'd1);
    idle();

    // reset during the second stall cycle of a READ_WAIT=2 read
    sel = 0;
    hold(16'h0123);
    check_eq("rst_pre1", 16'(rdy[0]), 16'd0);
    hold(16'h0123);
    check_eq("rst_pre2", 16'(rdy[0]), 16'd0);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_async_rdy", 16'(rdy[0]), 16'd1);
    check_eq("rst_async_oe",  16'(oe[0]),  16'd0);
    idle();
    check_eq("rst_held_rdy", 16'(rdy[0]), 16'd1);
    rst_n = 1'b1;
    rd(16'h0123, 8'hA5);
    check_eq("post_rst_stall1", 16'(rdy[0]), 16'd0);
    hold(16'h0123);
    check_eq("post_rst_stall2", 16'(rdy[0]), 16'd0);
    hold(16'h0123);
    check_eq("post_rst_data", 16'(oe[0]), 16'd1);
    rd(16'hD202, 8'h00);
    idle();

    check_eq("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
